instr_fetch_queue: RTL
======================

# instr_fetch_queue

Instruction fetch stage placed directly upstream of the single-cycle decode/execute datapath. It replaces the direct program-counter-to-instruction-memory path: it owns the fetch PC, issues requests to a variable-latency instruction memory over a request/grant/response handshake, and buffers returned instructions with their PCs in a small FIFO. It presents them to decode over a valid/ready interface. Branch redirects from execute flush the queue and discard in-flight responses.

## Interface
- DEPTH, 4: FIFO entries and maximum in-flight requests; power of two, ≥2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- redirect_i  in  1  taken branch from execute; flush and refetch.
- redirect_pc_i  in  32  new fetch address; bits [1:0] forced to 0.
- imem_req_o  out  1  fetch request valid.
- imem_addr_o  out  32  fetch address (= fetch PC).
- imem_gnt_i  in  1  request accepted this cycle when imem_req_o=1.
- imem_rvalid_i  in  1  in-order response valid, ≥1 cycle after its grant.
- imem_rdata_i  in  32  response instruction word.
- instr_valid_o  out  1  head entry valid.
- instr_o  out  32  head instruction; 0 when empty.
- pc_o  out  32  PC of head instruction; 0 when empty.
- instr_ready_i  in  1  decode consumes head when instr_valid_o=1.

## Operation
- State: fetch_pc, resp_pc (PC tag for next accepted response), FIFO count/read/write pointers, outstanding counter, discard counter (each counter log2(DEPTH)+1 bits).
- Reset (rst_i=0, immediate): fetch_pc=resp_pc=RESET_PC, count=outstanding=discard=0, FIFO pointers 0. Outputs while in reset: imem_req_o=0, instr_valid_o=0, instr_o=0, pc_o=0.
- Issue: imem_req_o = !redirect_i && (count + outstanding < DEPTH). On req&gnt: fetch_pc += 4 (mod 2^32), outstanding += 1.
- Response with discard>0: dropped, discard -= 1.
- Response with discard=0, outstanding>0: {imem_rdata_i, resp_pc} written to FIFO tail, resp_pc += 4, outstanding -= 1, count += 1. The FIFO cannot overflow by construction.
- imem_rvalid_i with outstanding=0 and discard=0 is a protocol error: ignored, flagged by bench assertion.
- Pop: instr_valid_o && instr_ready_i advances the head, count -= 1. Push and pop in the same cycle leave count unchanged, including at full.
- Redirect (highest priority):
  - FIFO cleared (count=0, pointers reset).
  - discard = discard + outstanding, counting any response arriving that same cycle.
  - outstanding=0; fetch_pc = resp_pc = {redirect_pc_i[31:2], 2'b00}.
  - A same-cycle pop or response has no effect on the queue.
  - Back-to-back redirects accumulate discard correctly.
- Requests resume the cycle after a redirect, even while discards are still pending.

## Timing
- Grant at cycle N, response at N+k (k≥1): instr_valid_o asserts at N+k+1 (registered FIFO, no bypass).
- Head outputs are combinational from FIFO storage at the read pointer. No output depends combinationally on instr_ready_i.
- imem_req_o depends combinationally on redirect_i and registered state only, not on imem_gnt_i.
- Sustained throughput: 1 instruction/cycle with 1-cycle memory and decode always ready.

## Configuration
- IFQ_STALL_CNT_EN defined:
  - Adds output stall_cnt_o (out, 32).
  - Increments each cycle that instr_ready_i=1 and instr_valid_o=0.
  - Saturates at 32'hFFFF_FFFF, resets to 0, and is not cleared by redirect.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset release, 1-cycle memory, ready=1: requests at 0x0, 0x4, 0x8…; instr_valid_o first high 2 cycles after the first grant; pc_o sequence 0x0, 0x4, 0x8 with one instruction per cycle.
- ready=0 with DEPTH=4: exactly 4 grants, then imem_req_o=0. count=4 holds instr at pc 0x0 head. One pop re-enables exactly one request.
- 3 requests outstanding, 3-cycle latency, redirect_i to 0x0000_0103: the next 3 responses are dropped. First valid instruction has pc_o=0x100 and the new data.
- Redirect in the same cycle as a response and a pop: FIFO empties, that response is counted as discarded, fetch restarts at redirect_pc.
- rst_i asserted low mid-stream with 2 outstanding: all outputs 0 immediately. After release, fetch restarts at RESET_PC; stale late responses are ignored.
- IFQ_STALL_CNT_EN defined, 5 empty cycles with ready=1: stall_cnt_o=5. Macro undefined: the module compiles without stall_cnt_o.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
//
// Fetch stage in front of the single-cycle decode/execute datapath. Owns the
// fetch PC, issues requests to a variable-latency instruction memory over a
// req/gnt + in-order rvalid handshake, and buffers returned words together with
// their PCs in a DEPTH-entry FIFO that decode drains over valid/ready.
// A redirect from execute flushes the FIFO and turns every request still in
// flight into a pending discard, so stale responses never reach decode.
//
// Optional feature: define IFQ_STALL_CNT_EN to add stall_cnt_o, a saturating
// count of cycles where decode was ready but no instruction was available.
// -----------------------------------------------------------------------------
// Handshakes:
//   * imem_req_o/imem_gnt_i : a request transfers on a cycle where both are 1.
//     imem_req_o never looks at imem_gnt_i.
//   * imem_rvalid_i         : one in-order response per cycle, no back-pressure.
//   * instr_valid_o/instr_ready_i : the head entry transfers on a cycle where
//     both are 1. instr_valid_o and the head data depend only on registered
//     state, never on instr_ready_i.
// -----------------------------------------------------------------------------
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    input  logic        instr_ready_i
`ifdef IFQ_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt_o
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    // Registered state
    logic [31:0]   fetch_pc_q;
    logic [31:0]   resp_pc_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] outstanding_q;
    logic [CW-1:0] discard_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;

    // FIFO storage: instruction word and its PC tag
    logic [31:0] instr_mem [DEPTH];
    logic [31:0] pc_mem    [DEPTH];

    // Per-cycle events
    logic          grant;
    logic          resp_drop;
    logic          resp_accept;
    logic          pop;
    logic [CW:0]   occupancy;
    logic [31:0]   redirect_pc;
    logic [CW-1:0] inflight_sum;
    logic [CW-1:0] redirect_discard;
    logic [CW-1:0] outstanding_nxt;
    logic [CW-1:0] count_nxt;

    // Entries already buffered plus entries promised by in-flight requests;
    // issuing only below DEPTH is what keeps the FIFO from ever overflowing.
    assign occupancy  = {1'b0, count_q} + {1'b0, outstanding_q};

    // Request is held low during reset and on a redirect cycle; the refetch
    // starts on the following cycle from the new fetch PC.
    assign imem_req_o  = rst_i && !redirect_i && (occupancy < DEPTH_W);
    assign imem_addr_o = fetch_pc_q;

    assign grant       = imem_req_o && imem_gnt_i;
    assign resp_drop   = imem_rvalid_i && (discard_q != '0);
    // A response with nothing outstanding and nothing to discard is a memory
    // protocol error; it is simply ignored here.
    assign resp_accept = imem_rvalid_i && (discard_q == '0) && (outstanding_q != '0);
    assign pop         = instr_valid_o && instr_ready_i;

    // Word-align the redirect target (masking keeps every input bit in use).
    assign redirect_pc = redirect_pc_i & 32'hFFFF_FFFC;

    // Responses still owed by memory at a redirect become discards. A response
    // arriving on the redirect cycle itself is one of them and is consumed now.
    // The counter width assumes memory never holds 2*DEPTH or more responses.
    assign inflight_sum = discard_q + outstanding_q;

    // Compute the discard count that a redirect this cycle would leave behind
    always_comb begin
        redirect_discard = inflight_sum;
        if (imem_rvalid_i && (inflight_sum != '0)) begin
            redirect_discard = inflight_sum - CW'(1);
        end
    end

    // Next outstanding count from grants issued and responses accepted
    always_comb begin
        outstanding_nxt = outstanding_q;
        case ({grant, resp_accept})
            2'b10:   outstanding_nxt = outstanding_q + CW'(1);
            2'b01:   outstanding_nxt = outstanding_q - CW'(1);
            default: outstanding_nxt = outstanding_q;
        endcase
    end

    // Next FIFO count from pushes and pops; simultaneous push/pop holds it
    always_comb begin
        count_nxt = count_q;
        case ({resp_accept, pop})
            2'b10:   count_nxt = count_q + CW'(1);
            2'b01:   count_nxt = count_q - CW'(1);
            default: count_nxt = count_q;
        endcase
    end

    // Control state: reset, redirect flush (highest priority), normal flow
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else if (redirect_i) begin
            fetch_pc_q    <= redirect_pc;
            resp_pc_q     <= redirect_pc;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= redirect_discard;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            count_q       <= count_nxt;
            outstanding_q <= outstanding_nxt;
            if (grant) begin
                fetch_pc_q <= fetch_pc_q + 32'd4;
            end
            if (resp_accept) begin
                resp_pc_q <= resp_pc_q + 32'd4;
                wr_ptr_q  <= wr_ptr_q + AW'(1);
            end
            if (resp_drop) begin
                discard_q <= discard_q - CW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    // FIFO storage write; contents are only observed through a valid head
    always_ff @(posedge clk_i) begin
        if (resp_accept && !redirect_i) begin
            instr_mem[wr_ptr_q] <= imem_rdata_i;
            pc_mem[wr_ptr_q]    <= resp_pc_q;
        end
    end

    // Head presentation straight from storage, forced to zero when empty
    assign instr_valid_o = (count_q != '0);
    assign instr_o       = instr_valid_o ? instr_mem[rd_ptr_q] : 32'h0;
    assign pc_o          = instr_valid_o ? pc_mem[rd_ptr_q]    : 32'h0;

`ifdef IFQ_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Count decode-starved cycles, saturating; redirects do not clear it
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
        end else if (instr_ready_i && !instr_valid_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
